alu_mc_dispatch: RTL and testbench
==================================

ALU_MC_DISPATCH -- requirements
Module: alu_mc_dispatch

Interface
REQ-001 SHALL have parameters: NUM_UNITS, default 4, number of multi-cycle responder units; TIMEOUT_CYCLES, default 64, maximum cycles to wait for done.
REQ-002 SHALL have ports: clk in 1 system clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have request ports: req_valid in 1 request present; req_ready out 1 dispatcher can accept; req_unit in 2 target unit id; req_op_a in XLEN operand A; req_op_b in XLEN operand B / shift amount; req_ctrl in 4 unit control bits; req_tag in 5 destination register tag.
REQ-004 SHALL have unit-side ports: unit_start out NUM_UNITS one-hot start pulse; unit_op_a out XLEN held operand A; unit_op_b out XLEN held operand B; unit_ctrl out 4 held control; unit_done in NUM_UNITS per-unit done; unit_result in NUM_UNITS*XLEN packed results, unit i at bits [i*XLEN +: XLEN].
REQ-005 SHALL have response ports: resp_valid out 1 result present; resp_ready in 1 consumer accepts; resp_data out XLEN result; resp_tag out 5 echoed tag; resp_error out 1 timeout or invalid unit; flush in 1 kill in-flight op; busy out 1 state not IDLE.

Function
REQ-006 SHALL implement states IDLE, LAUNCH, WAIT, RESP.
REQ-007 IDLE: req_ready=1; on req_valid&&req_ready SHALL capture unit, operands, ctrl, tag and go to LAUNCH.
REQ-008 LAUNCH: SHALL assert unit_start[unit] for exactly one cycle, clear watchdog count, go to WAIT.
REQ-009 If req_unit >= NUM_UNITS, LAUNCH SHALL assert no start and go to RESP with resp_error=1, resp_data=0.
REQ-010 unit_op_a/op_b/ctrl SHALL hold captured values, unchanged, from LAUNCH until the exit of WAIT; responders sample operands any cycle after start.
REQ-011 WAIT: SHALL consider only unit_done[unit]; when high, SHALL capture the matching unit_result slice and go to RESP next cycle; done of other units SHALL be ignored.
REQ-012 WAIT: watchdog SHALL increment once per cycle; when count reaches TIMEOUT_CYCLES-1 without done, SHALL go to RESP with resp_error=1, resp_data=0.
REQ-013 Done and timeout in the same cycle: done SHALL win, with resp_error=0.
REQ-014 RESP: resp_valid=1 and resp_data/tag/error stable until resp_valid&&resp_ready, then IDLE; req_ready=0 in RESP.
REQ-015 Flush in IDLE SHALL block acceptance that cycle; flush wins over req_valid.
REQ-016 Flush in LAUNCH SHALL suppress unit_start and return to IDLE.
REQ-017 Flush in WAIT SHALL set a discard flag; on done or timeout, SHALL return to IDLE with no response.
REQ-018 Flush in RESP SHALL drop the response and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Latency: accept edge to start = 1 cycle; done cycle to resp_valid = 1 cycle; back-to-back throughput = one op per (unit latency + 3) cycles.
REQ-021 Done pulses arriving in IDLE/LAUNCH/RESP SHALL be ignored.

Reset
REQ-022 On rst_n low, SHALL asynchronously enter IDLE with all captured registers, discard flag and watchdog count at 0.
REQ-023 Reset outputs SHALL be: req_ready=1 after release, unit_start=0, unit_op_a/op_b/ctrl=0, resp_valid=0, resp_data=0, resp_tag=0, resp_error=0, busy=0.
REQ-024 Reset mid-operation SHALL abandon the op with no response.

Structure
REQ-025 XLEN, MC_NUM_UNITS, MC_TIMEOUT_CYCLES and enum mc_unit_t (MC_SHIFT=0, MC_MUL=1, MC_DIV=2, MC_REM=3) SHALL live in core_config_pkg; the state enum SHALL be local.
REQ-026 The watchdog SHALL be a sub-module mc_watchdog (clear, enable, expired), width $clog2(TIMEOUT_CYCLES).

Verification
REQ-027 Request unit=0, op_a=0x8000_0000, op_b=4, unit model done after 3 cycles with result 0xF800_0000 -> single one-cycle start[0], resp_valid 1 cycle after done, data 0xF800_0000, tag echoed, error=0.
REQ-028 resp_ready held low 5 cycles -> resp_valid/data stable all 5 cycles, req_ready=0, then IDLE after the handshake.
REQ-029 Unit never asserts done -> resp_error=1, resp_data=0 after TIMEOUT_CYCLES wait cycles; a late done is ignored.
REQ-030 Flush 2 cycles after start, done after 6 cycles -> no resp_valid, busy low the cycle after done, next request accepted.
REQ-031 Spurious unit_done[2] while waiting on unit 1 -> ignored; result from unit 1 only.
REQ-032 rst_n asserted during WAIT -> all outputs at reset values immediately, no response after release.

Source files
------------

// File: rtl/core_config_pkg.sv
// Shared core configuration for the multi-cycle ALU dispatcher: datapath width,
// unit count, watchdog limit and the unit id encoding.
package core_config_pkg;
    localparam int XLEN              = 32;
    localparam int MC_NUM_UNITS      = 4;
    localparam int MC_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        MC_SHIFT = 2'd0,
        MC_MUL   = 2'd1,
        MC_DIV   = 2'd2,
        MC_REM   = 2'd3
    } mc_unit_t;
endpackage

// File: rtl/alu_mc_dispatch_watchdog.sv
// Wait-state watchdog: counts enabled cycles after a clear and flags when the
// count reaches TIMEOUT_CYCLES-1.
module mc_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = (count_reg == LAST);
endmodule

// File: rtl/alu_mc_dispatch.sv
// Dispatcher for multi-cycle ALU units: captures a request, pulses the target
// unit's start, waits for its done (with watchdog) and presents one response.
module alu_mc_dispatch
    import core_config_pkg::*;
#(
    parameter int NUM_UNITS      = MC_NUM_UNITS,
    parameter int TIMEOUT_CYCLES = MC_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_unit,
    input  logic [XLEN-1:0]           req_op_a,
    input  logic [XLEN-1:0]           req_op_b,
    input  logic [3:0]                req_ctrl,
    input  logic [4:0]                req_tag,
    output logic [NUM_UNITS-1:0]      unit_start,
    output logic [XLEN-1:0]           unit_op_a,
    output logic [XLEN-1:0]           unit_op_b,
    output logic [3:0]                unit_ctrl,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  logic [NUM_UNITS*XLEN-1:0] unit_result,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [XLEN-1:0]           resp_data,
    output logic [4:0]                resp_tag,
    output logic                      resp_error,
    input  logic                      flush,
    output logic                      busy
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          state_reg;
    mc_unit_t        unit_reg;
    logic [XLEN-1:0] op_a_reg;
    logic [XLEN-1:0] op_b_reg;
    logic [3:0]      ctrl_reg;
    logic [4:0]      tag_reg;
    logic [XLEN-1:0] data_reg;
    logic            error_reg;
    logic            discard_reg;

    logic [NUM_UNITS-1:0] unit_match;
    logic [XLEN-1:0]      sel_result;
    logic                 sel_done;
    logic                 unit_ok;
    logic                 launch_go;
    logic                 accept;
    logic                 discard_next;
    logic                 expired;

    assign unit_ok   = (int'(unit_reg) < NUM_UNITS);
    assign launch_go = (state_reg == ST_LAUNCH) && !flush;
    assign accept    = req_valid && req_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign unit_match[gi] = (int'(unit_reg) == gi);
            assign unit_start[gi] = launch_go && unit_match[gi];
        end
    endgenerate

    // Only the captured unit's done and result slice are ever observed.
    assign sel_done = |(unit_done & unit_match);

    always_comb begin
        sel_result = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_match[i]) begin
                sel_result = sel_result | unit_result[i*XLEN +: XLEN];
            end
        end
    end

    mc_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_reg == ST_LAUNCH),
        .enable (state_reg == ST_WAIT),
        .expired(expired)
    );

    assign discard_next = discard_reg || flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            unit_reg    <= MC_SHIFT;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            ctrl_reg    <= '0;
            tag_reg     <= '0;
            data_reg    <= '0;
            error_reg   <= 1'b0;
            discard_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        unit_reg    <= mc_unit_t'(req_unit);
                        op_a_reg    <= req_op_a;
                        op_b_reg    <= req_op_b;
                        ctrl_reg    <= req_ctrl;
                        tag_reg     <= req_tag;
                        discard_reg <= 1'b0;
                        state_reg   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                    end else if (!unit_ok) begin
                        data_reg  <= '0;
                        error_reg <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Done takes priority over a simultaneous watchdog expiry.
                    if (sel_done) begin
                        data_reg    <= sel_result;
                        error_reg   <= 1'b0;
                        discard_reg <= 1'b0;
                        state_reg   <= discard_next ? ST_IDLE : ST_RESP;
                    end else if (expired) begin
                        data_reg    <= '0;
                        error_reg   <= 1'b1;
                        discard_reg <= 1'b0;
                        state_reg   <= discard_next ? ST_IDLE : ST_RESP;
                    end else begin
                        discard_reg <= discard_next;
                    end
                end
                ST_RESP: begin
                    if (flush || resp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_reg == ST_IDLE) && !flush;
    assign resp_valid = (state_reg == ST_RESP);
    assign busy       = (state_reg != ST_IDLE);
    assign unit_op_a  = op_a_reg;
    assign unit_op_b  = op_b_reg;
    assign unit_ctrl  = ctrl_reg;
    assign resp_data  = data_reg;
    assign resp_tag   = tag_reg;
    assign resp_error = error_reg;
endmodule

// File: tb/tb_alu_mc_dispatch.sv
// Randomised bench for alu_mc_dispatch with a bench-side unit responder and a
// transaction-level model of the expected response.
module tb_alu_mc_dispatch;
    localparam int W  = 32;
    localparam int NU = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_unit;
    logic [W-1:0]    req_op_a;
    logic [W-1:0]    req_op_b;
    logic [3:0]      req_ctrl;
    logic [4:0]      req_tag;
    logic [NU-1:0]   unit_start;
    logic [W-1:0]    unit_op_a;
    logic [W-1:0]    unit_op_b;
    logic [3:0]      unit_ctrl;
    logic [NU-1:0]   unit_done;
    logic [NU*W-1:0] unit_result;
    logic            resp_valid;
    logic            resp_ready;
    logic [W-1:0]    resp_data;
    logic [4:0]      resp_tag;
    logic            resp_error;
    logic            flush;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    alu_mc_dispatch #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
        .unit_start(unit_start), .unit_op_a(unit_op_a), .unit_op_b(unit_op_b),
        .unit_ctrl(unit_ctrl), .unit_done(unit_done), .unit_result(unit_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_error(resp_error), .flush(flush), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // What each responder computes; the dispatcher must forward it untouched.
    function automatic logic [31:0] ref_result(input int u, input logic [31:0] a, input logic [31:0] b);
        case (u)
            0:       return 32'($signed(a) >>> b[4:0]);
            1:       return a * b;
            2:       return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic set_results(input int u, input logic [31:0] val, input bit hit);
        for (int i = 0; i < NU; i++) begin
            unit_result[i*W +: W] = (hit && i == u) ? val : $urandom;
        end
    endtask

    task automatic run_txn(input int u, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [4:0] t, input int lat,
                           input int rdly, input int fk, input bit spur,
                           input bit rflush, input bit late_done);
        logic [31:0] exp_res;
        int          exit_k;
        bit          err;
        bit          flushed;
        exp_res = ref_result(u, a, b);
        exit_k  = (lat < TO) ? lat : TO;
        err     = (lat > TO);
        flushed = (fk > 0) && (fk <= exit_k);

        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        req_valid = 1'b1; req_unit = 2'(u); req_op_a = a; req_op_b = b;
        req_ctrl = c; req_tag = t;
        @(negedge clk);
        req_valid = 1'b0; req_op_a = $urandom; req_op_b = $urandom; req_ctrl = 4'($urandom);
        check("launch_start", 32'(unit_start), 32'(4'(1) << u));
        check("launch_busy", 32'(busy), 32'd1);
        check("launch_op_a", unit_op_a, a);
        for (int k = 1; k <= exit_k; k++) begin
            @(negedge clk);
            check("wait_resp_valid", 32'(resp_valid), 32'd0);
            check("wait_start", 32'(unit_start), 32'd0);
            check("wait_op_b", unit_op_b, b);
            check("wait_ctrl", 32'(unit_ctrl), 32'(c));
            unit_done = ((k == lat) ? 4'(1) << u : 4'd0)
                      | ((spur && k < lat) ? 4'(1) << ((u + 1) % NU) : 4'd0);
            set_results(u, exp_res, k == lat);
            flush = (k == fk);
        end
        @(negedge clk);
        unit_done = '0; flush = 1'b0; set_results(u, 32'd0, 1'b0);
        if (flushed) begin
            check("flushed_resp_valid", 32'(resp_valid), 32'd0);
            check("flushed_busy", 32'(busy), 32'd0);
        end else begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_req_ready", 32'(req_ready), 32'd0);
            check("resp_data", resp_data, err ? 32'd0 : exp_res);
            check("resp_tag", 32'(resp_tag), 32'(t));
            check("resp_error", 32'(resp_error), 32'(err));
            if (rflush) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                check("rflush_resp_valid", 32'(resp_valid), 32'd0);
                check("rflush_busy", 32'(busy), 32'd0);
            end else begin
                for (int d = 0; d < rdly; d++) begin
                    resp_ready = 1'b0;
                    @(negedge clk);
                    check("stall_resp_valid", 32'(resp_valid), 32'd1);
                    check("stall_resp_data", resp_data, err ? 32'd0 : exp_res);
                    check("stall_req_ready", 32'(req_ready), 32'd0);
                end
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                check("post_resp_valid", 32'(resp_valid), 32'd0);
                check("post_busy", 32'(busy), 32'd0);
            end
        end
        if (late_done) begin
            unit_done = 4'(1) << u;
            @(negedge clk);
            unit_done = '0;
            check("late_done_valid", 32'(resp_valid), 32'd0);
            check("late_done_busy", 32'(busy), 32'd0);
        end
        n_txn++;
        $display("txn %0d unit=%0d a=%h b=%h tag=%0d lat=%0d flush_k=%0d exp=%h err=%0d",
                 n_txn, u, a, b, t, lat, fk, exp_res, err);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_unit = '0; req_op_a = '0; req_op_b = '0;
        req_ctrl = '0; req_tag = '0; unit_done = '0; unit_result = '0;
        resp_ready = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(unit_start), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_op_a", unit_op_a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Directed scenarios: basic shift, stalled consumer, timeout with late done,
        // done/timeout tie, one past the tie, flush in WAIT, spurious done, flush in RESP.
        run_txn(0, 32'h8000_0000, 32'd4, 4'h1, 5'd7, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        check("shift_ref", ref_result(0, 32'h8000_0000, 32'd4), 32'hF800_0000);
        run_txn(1, 32'd1234, 32'd5678, 4'h2, 5'd9, 2, 5, 0, 1'b0, 1'b0, 1'b0);
        run_txn(2, 32'd100, 32'd7, 4'h3, 5'd11, 500, 0, 0, 1'b0, 1'b0, 1'b1);
        run_txn(3, 32'd100, 32'd7, 4'h4, 5'd12, TO, 1, 0, 1'b0, 1'b0, 1'b0);
        run_txn(3, 32'd100, 32'd7, 4'h4, 5'd13, TO + 1, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn(2, 32'd99, 32'd3, 4'h5, 5'd14, 6, 0, 2, 1'b0, 1'b0, 1'b0);
        run_txn(1, 32'h55, 32'h3, 4'h6, 5'd15, 4, 0, 0, 1'b1, 1'b0, 1'b0);
        run_txn(0, 32'hF0, 32'd2, 4'h7, 5'd16, 2, 0, 0, 1'b0, 1'b1, 1'b0);

        // Flush alongside a request in IDLE blocks acceptance.
        @(negedge clk);
        req_valid = 1'b1; req_unit = 2'd1; flush = 1'b1;
        #1 check("idle_flush_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 32'(busy), 32'd0);
        check("idle_flush_start", 32'(unit_start), 32'd0);

        // Flush in LAUNCH suppresses the start pulse.
        @(negedge clk);
        req_valid = 1'b1; req_unit = 2'd2; req_tag = 5'd20;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        #1 check("launch_flush_start", 32'(unit_start), 32'd0);
        @(negedge clk);
        flush = 1'b0; unit_done = 4'b0100;
        check("launch_flush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        unit_done = '0;
        check("launch_flush_valid", 32'(resp_valid), 32'd0);

        // Asynchronous reset in WAIT abandons the op.
        @(negedge clk);
        req_valid = 1'b1; req_unit = 2'd1; req_op_a = 32'hABCD; req_op_b = 32'h12;
        req_ctrl = 4'hF; req_tag = 5'd21;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_op_a", unit_op_a, 32'd0);
        check("arst_op_b", unit_op_b, 32'd0);
        check("arst_ctrl", 32'(unit_ctrl), 32'd0);
        check("arst_tag", 32'(resp_tag), 32'd0);
        check("arst_error", 32'(resp_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; unit_done = 4'b0010;
        @(negedge clk);
        unit_done = '0;
        check("arst_no_resp", 32'(resp_valid), 32'd0);
        check("arst_idle", 32'(req_ready), 32'd1);

        for (int n = 0; n < 40; n++) begin
            int lat;
            int fk;
            int cap;
            lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70))
                                              : int'($urandom_range(1, 10));
            cap = (lat < TO) ? lat : TO;
            fk  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, cap)) : 0;
            run_txn(int'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom),
                    5'($urandom), lat, int'($urandom_range(0, 3)), fk,
                    1'($urandom), ($urandom_range(0, 9) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
